// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU operation
// codes (also used by the ALU) and FSM state encoding.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  // Returns {unsupported, alu_ctrl} for the ALU-class opcodes.
  // is_r selects the R-type meaning of instr[30] for funct3=000.
  function automatic logic [4:0] alu_funct(input logic [2:0] funct3,
                                           input logic       is_r,
                                           input logic       bit30);
    logic [4:0] r;
    r = {1'b0, ALU_ADD};
    case (funct3)
      3'b000:  r = {1'b0, (is_r && bit30) ? ALU_SUB : ALU_ADD};
      3'b001:  r = {1'b0, ALU_SLL};
      3'b010:  r = {1'b0, ALU_SLT};
      3'b100:  r = {1'b0, ALU_XOR};
      3'b101:  r = {1'b0, bit30 ? ALU_SRA : ALU_SRL};
      3'b110:  r = {1'b0, ALU_OR};
      3'b111:  r = {1'b0, ALU_AND};
      default: r = {1'b1, ALU_ADD};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decoder; flags unknown opcodes and unsupported
// funct3 values, forcing ADD so an illegal instruction behaves as a NOP.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       bit30,
  output logic [3:0] alu_ctrl,
  output logic       unsupported
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    unsupported = 1'b0;
    case (opcode)
      OP_R:          {unsupported, alu_ctrl} = alu_funct(funct3, 1'b1, bit30);
      OP_I:          {unsupported, alu_ctrl} = alu_funct(funct3, 1'b0, bit30);
      OP_LW, OP_SW:  alu_ctrl = ALU_ADD;
      OP_BEQ:        alu_ctrl = ALU_SUB;
      default:       unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Five-state multicycle control unit (IF, ID, EX, MEM, WB) for an RV32I
// subset; all datapath controls are combinational from state, instr and Zero.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 Zero,
  output logic                 PCSrc,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic                 MemToReg,
  output logic [ALUCTRL_W-1:0] ALUCtrl,
  output logic                 loadPC,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 illegal,
  output logic [2:0]           state_o
);

  state_t state_q;
  state_t state_d;
  state_t state_eff;

  logic [6:0] opcode;
  logic [3:0] dec_ctrl;
  logic       dec_unsup;
  logic       is_r, is_i, is_lw, is_sw, is_beq;
  logic       dec_alu_src;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct3      (instr[14:12]),
    .bit30       (instr[30]),
    .alu_ctrl    (dec_ctrl),
    .unsupported (dec_unsup)
  );

  assign is_r   = (opcode == OP_R)   && !dec_unsup;
  assign is_i   = (opcode == OP_I)   && !dec_unsup;
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);
  assign dec_alu_src = is_i || is_lw || is_sw;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:    state_d = S_ID;
      S_ID:    state_d = S_EX;
      S_EX:    state_d = S_MEM;
      S_MEM:   state_d = S_WB;
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // While rst is high the outputs already look like IF, so an instruction
  // aborted by reset cannot issue its MEM or WB writes in that cycle.
  assign state_eff = rst ? S_IF : state_q;
  assign state_o   = state_q;

  always_comb begin
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUCtrl  = ALU_ADD;
    loadPC   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    illegal  = 1'b0;
    if (state_eff == S_EX || state_eff == S_MEM || state_eff == S_WB) begin
      ALUSrc  = dec_alu_src;
      ALUCtrl = dec_ctrl;
      illegal = dec_unsup;
    end
    case (state_eff)
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      S_WB: begin
        loadPC   = 1'b1;
        PCSrc    = is_beq && Zero;
        RegWrite = is_r || is_i || is_lw;
        MemToReg = is_lw;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction expected output words
// are hand-written and checked cycle by cycle in IF..WB order.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        Zero;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state_o;

  int n_cmp;
  int n_bad;

  // Word layout: [14:12] state, 11 PCSrc, 10 ALUSrc, 9 RegWrite, 8 MemToReg,
  // [7:4] ALUCtrl, 3 loadPC, 2 MemRead, 1 MemWrite, 0 illegal.
  logic [14:0] exp_q[$];
  logic [14:0] care;

  multicycle_ctrl #(.ALUCTRL_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .Zero     (Zero),
    .PCSrc    (PCSrc),
    .ALUSrc   (ALUSrc),
    .RegWrite (RegWrite),
    .MemToReg (MemToReg),
    .ALUCtrl  (ALUCtrl),
    .loadPC   (loadPC),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .illegal  (illegal),
    .state_o  (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] w(input logic [2:0] st, input logic pcs, input logic asrc,
                                    input logic rw, input logic m2r, input logic [3:0] ctrl,
                                    input logic lpc, input logic mr, input logic mw,
                                    input logic ill);
    return {st, pcs, asrc, rw, m2r, ctrl, lpc, mr, mw, ill};
  endfunction

  function automatic logic [14:0] observed();
    return {state_o, PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, illegal};
  endfunction

  task automatic check(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = observed();
    n_cmp++;
    assert ((obs & care) === (exp & care))
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs & care, exp & care);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered just after an edge with state IF; leaves the same way.
  task automatic run_instr(input string tag, input logic [31:0] ins, input logic z);
    instr = ins;
    Zero  = z;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_c%0d", tag, i), exp_q.pop_front());
      tick();
    end
    check({tag, "_back_if"}, w(3'd0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
  endtask

  task automatic push_front_end();
    exp_q.push_back(w(3'd0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
    exp_q.push_back(w(3'd1, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    care  = '1;
    rst   = 1'b1;
    instr = 32'h0050_0093;
    Zero  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_c%0d", i), w(3'd0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
    end
    rst = 1'b0;

    // addi x1,x0,5
    push_front_end();
    exp_q.push_back(w(3'd2, 0, 1, 0, 0, 4'b0010, 0, 0, 0, 0));
    exp_q.push_back(w(3'd3, 0, 1, 0, 0, 4'b0010, 0, 0, 0, 0));
    exp_q.push_back(w(3'd4, 0, 1, 1, 0, 4'b0010, 1, 0, 0, 0));
    run_instr("addi", 32'h0050_0093, 1'b0);

    // sub x3,x1,x2
    push_front_end();
    exp_q.push_back(w(3'd2, 0, 0, 0, 0, 4'b0110, 0, 0, 0, 0));
    exp_q.push_back(w(3'd3, 0, 0, 0, 0, 4'b0110, 0, 0, 0, 0));
    exp_q.push_back(w(3'd4, 0, 0, 1, 0, 4'b0110, 1, 0, 0, 0));
    run_instr("sub", 32'h4020_81B3, 1'b0);

    // add x3,x1,x2, Zero high must not matter
    push_front_end();
    exp_q.push_back(w(3'd2, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
    exp_q.push_back(w(3'd3, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
    exp_q.push_back(w(3'd4, 0, 0, 1, 0, 4'b0010, 1, 0, 0, 0));
    run_instr("add", 32'h0020_81B3, 1'b1);

    // srai x1,x1,5
    push_front_end();
    exp_q.push_back(w(3'd2, 0, 1, 0, 0, 4'b1010, 0, 0, 0, 0));
    exp_q.push_back(w(3'd3, 0, 1, 0, 0, 4'b1010, 0, 0, 0, 0));
    exp_q.push_back(w(3'd4, 0, 1, 1, 0, 4'b1010, 1, 0, 0, 0));
    run_instr("srai", 32'h4050_D093, 1'b0);

    // lw x5,8(x1)
    push_front_end();
    exp_q.push_back(w(3'd2, 0, 1, 0, 0, 4'b0010, 0, 0, 0, 0));
    exp_q.push_back(w(3'd3, 0, 1, 0, 0, 4'b0010, 0, 1, 0, 0));
    exp_q.push_back(w(3'd4, 0, 1, 1, 1, 4'b0010, 1, 0, 0, 0));
    run_instr("lw", 32'h0080_A283, 1'b0);

    // sw x5,4(x1)
    push_front_end();
    exp_q.push_back(w(3'd2, 0, 1, 0, 0, 4'b0010, 0, 0, 0, 0));
    exp_q.push_back(w(3'd3, 0, 1, 0, 0, 4'b0010, 0, 0, 1, 0));
    exp_q.push_back(w(3'd4, 0, 1, 0, 0, 4'b0010, 1, 0, 0, 0));
    run_instr("sw", 32'h0050_A223, 1'b0);

    // beq taken
    push_front_end();
    exp_q.push_back(w(3'd2, 0, 0, 0, 0, 4'b0110, 0, 0, 0, 0));
    exp_q.push_back(w(3'd3, 0, 0, 0, 0, 4'b0110, 0, 0, 0, 0));
    exp_q.push_back(w(3'd4, 1, 0, 0, 0, 4'b0110, 1, 0, 0, 0));
    run_instr("beq_z1", 32'h0020_8463, 1'b1);

    // beq not taken
    push_front_end();
    exp_q.push_back(w(3'd2, 0, 0, 0, 0, 4'b0110, 0, 0, 0, 0));
    exp_q.push_back(w(3'd3, 0, 0, 0, 0, 4'b0110, 0, 0, 0, 0));
    exp_q.push_back(w(3'd4, 0, 0, 0, 0, 4'b0110, 1, 0, 0, 0));
    run_instr("beq_z0", 32'h0020_8463, 1'b0);

    // Illegal cases: ALUSrc is left unconstrained for them.
    care = 15'h7BFF;
    push_front_end();
    exp_q.push_back(w(3'd2, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 1));
    exp_q.push_back(w(3'd3, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 1));
    exp_q.push_back(w(3'd4, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 1));
    run_instr("bad_op", 32'h0000_007F, 1'b1);

    push_front_end();
    exp_q.push_back(w(3'd2, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 1));
    exp_q.push_back(w(3'd3, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 1));
    exp_q.push_back(w(3'd4, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 1));
    run_instr("sltu", 32'h0020_B1B3, 1'b0);
    care = '1;

    // sw aborted by reset in MEM: no write pulse, then a fresh nop runs.
    instr = 32'h0050_A223;
    Zero  = 1'b0;
    #1;
    check("abort_if", w(3'd0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
    tick();
    check("abort_id", w(3'd1, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
    tick();
    check("abort_ex", w(3'd2, 0, 1, 0, 0, 4'b0010, 0, 0, 0, 0));
    tick();
    rst = 1'b1;
    #1;
    check("abort_mem_rst", w(3'd3, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));
    tick();
    rst = 1'b0;
    instr = 32'h0000_0013;
    #1;
    check("abort_after", w(3'd0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0));

    push_front_end();
    exp_q.push_back(w(3'd2, 0, 1, 0, 0, 4'b0010, 0, 0, 0, 0));
    exp_q.push_back(w(3'd3, 0, 1, 0, 0, 4'b0010, 0, 0, 0, 0));
    exp_q.push_back(w(3'd4, 0, 1, 1, 0, 4'b0010, 1, 0, 0, 0));
    run_instr("nop_after_abort", 32'h0000_0013, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
